plru_repl_ctrl: RTL and testbench
=================================

Name: plru_repl_ctrl

Overview:
- Per-set 4-way tree-PLRU state store and replacement controller for the L1 cache.
- Accepts one access per cycle from the tag-compare stage, carrying a set index and a hit/miss flag with the hit way.
- On a miss it picks the victim way; on a hit it uses the hit way. It then writes back the updated 3-bit PLRU state and returns the chosen way to the fill/refill logic.
- Owns the state array, the power-on/flush clear sweep, and read-after-write forwarding.

Parameters:
- NUM_SETS, 64, number of cache sets; power of two, >= 2.
- SET_W, $clog2(NUM_SETS), set index width; localparam, derived.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- flush  in  1  single-cycle pulse; re-clears all PLRU state.
- acc_valid  in  1  access request valid.
- acc_ready  out  1  request accepted when acc_valid & acc_ready.
- acc_set  in  SET_W  set index of the access.
- acc_hit  in  1  1 = hit, 0 = miss.
- acc_way  in  2  hit way; ignored when acc_hit=0.
- rsp_valid  out  1  one-cycle pulse per accepted access.
- rsp_set  out  SET_W  set index of the response.
- rsp_way  out  2  hit way, or victim way on a miss.
- rsp_plru  out  3  PLRU state written back for rsp_set.
- init_done  out  1  1 when state==RUN.

Behaviour:
- Reset: asynchronous, active-low.
  - While rst_n=0: state=INIT, init counter=0, S1 valid=0, rsp_valid=0, rsp_set=0, rsp_way=0, rsp_plru=0, init_done=0, acc_ready=0.
  - The state array itself is not reset; it is cleared by the INIT sweep.
- FSM INIT:
  - Each cycle writes 3'b000 to array[cnt], then cnt++.
  - After the write at cnt==NUM_SETS-1, next state is RUN.
  - The sweep takes exactly NUM_SETS cycles after reset release.
- FSM RUN:
  - acc_ready = (state==RUN) & ~flush. This is combinational; flush has priority over a same-cycle request.
  - A flush pulse in RUN moves the FSM to INIT at the next edge with cnt=0.
  - flush in INIT restarts the sweep at cnt=0.
- Pipeline, throughput 1/cycle, no backpressure:
  - Edge E0 (accept): capture set/hit/way into S1 and perform a registered read of array[acc_set] into S1.plru.
  - Edge E1: write new_plru to array[S1.set]. Register rsp_*; rsp_valid=1 for one cycle.
  - Latency: response visible two edges after acc_valid is presented, i.e. after E1.
- Forwarding:
  - If a request is accepted at the same edge S1 writes back, and acc_set==S1.set, S1.plru takes S1's new_plru instead of the stale array value.
  - Back-to-back accesses to one set must therefore behave exactly as if serialized.
- Bit meaning (b[2]=root, b[1]=left node, b[0]=right node):
  - b2=1 means the right subtree {2,3} is LRU.
  - b1=1 means way1 is LRU within {0,1}.
  - b0=1 means way3 is LRU within {2,3}.
- Victim selection: b2=0 selects way b1?1:0; b2=1 selects way b0?3:2.
- Chosen way = acc_hit ? acc_way : victim.
- Update on access to the chosen way (the bit not listed keeps its old value):
  - way0: b2=1, b1=1.
  - way1: b2=1, b1=0.
  - way2: b2=0, b0=1.
  - way3: b2=0, b0=0.
- An in-flight S1 at the flush edge still completes its write and response. The sweep then overwrites it.
- Reset mid-operation: the in-flight access is dropped, no response is produced, and the sweep restarts.

Decomposition:
- Shared package (cache_pkg):
  - PLRU_W=3, WAYS=4, WAY_W=2.
  - Bit-index constants PLRU_ROOT=2, PLRU_L=1, PLRU_R=0.
  - Functions plru_victim(plru) and plru_next(plru, way).
- Sub-module plru_victim_sel: combinational victim decode plus next-state computation (plru, hit, hit_way -> way, new_plru).
- The array, FSM and forwarding stay in plru_repl_ctrl.

Test Plan:
- Reset release with NUM_SETS=64 -> acc_ready=0 for 64 cycles, then 1 and init_done=1. Miss on set 5 -> rsp_way=0, rsp_plru=3'b110 two edges later.
- Four back-to-back misses on set 5 with no gaps (forwarding) -> rsp_way 0,2,1,3, rsp_plru 110,011,101,000; a fifth miss -> way 0.
- Hit way2 on set 9, then miss on set 9 the next cycle -> rsp_plru 001, then victim way0 with rsp_plru 111.
- Interleaved misses on sets 1,2,1 -> ways 0,0,2; set 2 unaffected by set 1 updates.
- flush pulsed in the same cycle as acc_valid, with one access in flight:
  - The in-flight response is still produced; the same-cycle request is not accepted.
  - acc_ready=0 for 64 cycles.
  - Afterwards a miss on set 5 -> way0, plru 110.
- rst_n asserted for one cycle while S1 is valid -> rsp_valid=0 immediately, no response, full 64-cycle sweep before acc_ready=1.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared L1 cache types and tree-PLRU helpers (victim decode, next-state update).
// Latency: n/a (pure types and combinational functions).
// Backpressure: n/a.
package cache_pkg;

  localparam int PLRU_W = 3;
  localparam int WAYS   = 4;
  localparam int WAY_W  = 2;

  // Bit positions inside the 3-bit tree: root, left node {0,1}, right node {2,3}.
  localparam int PLRU_ROOT = 2;
  localparam int PLRU_L    = 1;
  localparam int PLRU_R    = 0;

  typedef logic [PLRU_W-1:0] plru_t;
  typedef logic [WAY_W-1:0]  way_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_t;

  // Follow the tree towards the LRU leaf.
  function automatic way_t plru_victim(plru_t p);
    way_t w;
    if (p[PLRU_ROOT]) w = p[PLRU_R] ? way_t'(3) : way_t'(2);
    else              w = p[PLRU_L] ? way_t'(1) : way_t'(0);
    return w;
  endfunction

  // Point every node on the path to the accessed way away from it.
  function automatic plru_t plru_next(plru_t p, way_t w);
    plru_t n;
    n = p;
    case (w)
      way_t'(0): begin n[PLRU_ROOT] = 1'b1; n[PLRU_L] = 1'b1; end
      way_t'(1): begin n[PLRU_ROOT] = 1'b1; n[PLRU_L] = 1'b0; end
      way_t'(2): begin n[PLRU_ROOT] = 1'b0; n[PLRU_R] = 1'b1; end
      default:   begin n[PLRU_ROOT] = 1'b0; n[PLRU_R] = 1'b0; end
    endcase
    return n;
  endfunction

endpackage

// File: rtl/plru_repl_ctrl_if.sv
// Access request / replacement response bundle between tag-compare and the PLRU controller.
// Latency: n/a (wires only).
// Backpressure: requester holds acc_valid until acc_ready; responses are unthrottled pulses.
interface plru_repl_ctrl_if #(
  parameter int SET_W = 6
);
  import cache_pkg::*;

  logic             acc_valid;
  logic             acc_ready;
  logic [SET_W-1:0] acc_set;
  logic             acc_hit;
  way_t             acc_way;

  logic             rsp_valid;
  logic [SET_W-1:0] rsp_set;
  way_t             rsp_way;
  plru_t            rsp_plru;

  modport master (
    output acc_valid, acc_set, acc_hit, acc_way,
    input  acc_ready, rsp_valid, rsp_set, rsp_way, rsp_plru
  );

  modport slave (
    input  acc_valid, acc_set, acc_hit, acc_way,
    output acc_ready, rsp_valid, rsp_set, rsp_way, rsp_plru
  );

endinterface

// File: rtl/plru_repl_ctrl_victim_sel.sv
// Chooses the way for an access (hit way or PLRU victim) and the updated tree state.
// Latency: combinational.
// Backpressure: none.
module plru_victim_sel
  import cache_pkg::*;
(
  input  plru_t plru,
  input  logic  hit,
  input  way_t  hit_way,
  output way_t  way,
  output plru_t new_plru
);

  assign way      = hit ? hit_way : plru_victim(plru);
  assign new_plru = plru_next(plru, way);

endmodule

// File: rtl/plru_repl_ctrl.sv
// Per-set 4-way tree-PLRU store: picks victim/hit way, writes back state, clear sweep on reset/flush.
// Latency: response registered two edges after the request is presented (accept edge + writeback edge).
// Backpressure: acc_ready low only during the clear sweep or a flush cycle; otherwise 1 access/cycle.
module plru_repl_ctrl
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  output logic            init_done,
  plru_repl_ctrl_if.slave bus
);

  localparam int SET_W = $clog2(NUM_SETS);

  ctrl_state_t      state;
  logic [SET_W-1:0] cnt;

  // Stage-1 holds the accepted access while its PLRU state is being updated.
  logic             s1_vld;
  logic [SET_W-1:0] s1_set;
  logic             s1_hit;
  way_t             s1_way;
  plru_t            s1_plru;

  way_t             sel_way;
  plru_t            new_plru;

  // State array deliberately has no reset; the INIT sweep clears it.
  plru_t            plru_mem [NUM_SETS];

  logic             accept;
  logic             fwd;

  assign bus.acc_ready = (state == ST_RUN) & ~flush;
  assign accept        = bus.acc_valid & bus.acc_ready;
  assign init_done     = (state == ST_RUN);

  // A request to the set being written back this edge must see the new value.
  assign fwd = s1_vld & (s1_set == bus.acc_set);

  plru_victim_sel u_sel (
    .plru     (s1_plru),
    .hit      (s1_hit),
    .hit_way  (s1_way),
    .way      (sel_way),
    .new_plru (new_plru)
  );

  // Sweep/run control; flush restarts the sweep from set 0 in either state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else if (flush) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else if (state == ST_INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == SET_W'(NUM_SETS - 1)) state <= ST_RUN;
    end
  end

  // Array write port: sweep clears one set per cycle, otherwise stage-1 writes back.
  always_ff @(posedge clk) begin
    if (state == ST_INIT)  plru_mem[cnt]    <= '0;
    else if (s1_vld)       plru_mem[s1_set] <= new_plru;
  end

  // Accept stage: capture the request and read (or forward) its PLRU state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_set  <= '0;
      s1_hit  <= 1'b0;
      s1_way  <= '0;
      s1_plru <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_set  <= bus.acc_set;
        s1_hit  <= bus.acc_hit;
        s1_way  <= bus.acc_way;
        s1_plru <= fwd ? new_plru : plru_mem[bus.acc_set];
      end
    end
  end

  // Response registers: one-cycle pulse per completed writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_set   <= '0;
      bus.rsp_way   <= '0;
      bus.rsp_plru  <= '0;
    end else begin
      bus.rsp_valid <= s1_vld;
      if (s1_vld) begin
        bus.rsp_set  <= s1_set;
        bus.rsp_way  <= sel_way;
        bus.rsp_plru <= new_plru;
      end
    end
  end

endmodule

// File: tb/tb_plru_repl_ctrl.sv
// Directed bench for plru_repl_ctrl: sweep timing, PLRU sequences, forwarding, flush and reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_plru_repl_ctrl;
  import cache_pkg::*;

  localparam int NUM_SETS = 64;
  localparam int SET_W    = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic init_done;

  always #5 clk = ~clk;

  plru_repl_ctrl_if #(.SET_W(SET_W)) bus();

  plru_repl_ctrl #(.NUM_SETS(NUM_SETS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .init_done (init_done),
    .bus       (bus)
  );

  int errors = 0;
  int checks = 0;

  // Directed vector table used by run_seq.
  int          v_n;
  logic [5:0]  v_set  [8];
  logic        v_hit  [8];
  logic [1:0]  v_way  [8];
  logic [1:0]  e_way  [8];
  logic [2:0]  e_plru [8];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [5:0] s, input logic h, input logic [1:0] w,
                         input logic [1:0] ew, input logic [2:0] ep);
    v_set[i]  = s;
    v_hit[i]  = h;
    v_way[i]  = w;
    e_way[i]  = ew;
    e_plru[i] = ep;
  endtask

  // Issue v_n requests on consecutive cycles; response i appears one cycle after request i+1 is driven.
  task automatic run_seq(input string name);
    for (int i = 0; i <= v_n; i++) begin
      if (i < v_n) begin
        bus.acc_valid = 1'b1;
        bus.acc_set   = v_set[i];
        bus.acc_hit   = v_hit[i];
        bus.acc_way   = v_way[i];
        #1;
        checks++;
        if (bus.acc_ready !== 1'b1) begin
          errors++;
          $display("FAIL %s[%0d] acc_ready got=%b exp=1", name, i, bus.acc_ready);
        end
      end else begin
        bus.acc_valid = 1'b0;
      end
      step;
      if (i == 0) begin
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s early rsp_valid got=%b exp=0", name, bus.rsp_valid);
        end
      end else begin
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_set !== v_set[i-1] ||
            bus.rsp_way !== e_way[i-1] || bus.rsp_plru !== e_plru[i-1]) begin
          errors++;
          $display("FAIL %s[%0d] got valid=%b set=%0d way=%0d plru=%b exp valid=1 set=%0d way=%0d plru=%b",
                   name, i-1, bus.rsp_valid, bus.rsp_set, bus.rsp_way, bus.rsp_plru,
                   v_set[i-1], e_way[i-1], e_plru[i-1]);
        end
      end
    end
    step;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s trailing rsp_valid got=%b exp=0", name, bus.rsp_valid);
    end
  endtask

  // Count edges until acc_ready rises (bounded); flags any response seen meanwhile.
  task automatic wait_sweep(input string name);
    int n;
    logic saw_rsp;
    n = 0;
    saw_rsp = 1'b0;
    while (bus.acc_ready !== 1'b1 && n < 200) begin
      step;
      n++;
      if (bus.rsp_valid === 1'b1) saw_rsp = 1'b1;
    end
    checks++;
    if (n != NUM_SETS) begin
      errors++;
      $display("FAIL %s sweep_cycles got=%0d exp=%0d", name, n, NUM_SETS);
    end
    checks++;
    if (saw_rsp !== 1'b0) begin
      errors++;
      $display("FAIL %s rsp_during_sweep got=%b exp=0", name, saw_rsp);
    end
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL %s init_done got=%b exp=1", name, init_done);
    end
  endtask

  task automatic test_reset;
    bus.acc_valid = 1'b0;
    bus.acc_set   = '0;
    bus.acc_hit   = 1'b0;
    bus.acc_way   = '0;
    rst_n = 1'b0;
    #1;
    repeat (3) step;
    checks++;
    if (bus.acc_ready !== 1'b0 || init_done !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got ready=%b done=%b rsp_valid=%b exp 0/0/0",
               bus.acc_ready, init_done, bus.rsp_valid);
    end
    checks++;
    if (bus.rsp_set !== 6'd0 || bus.rsp_way !== 2'd0 || bus.rsp_plru !== 3'b000) begin
      errors++;
      $display("FAIL reset_rsp got set=%0d way=%0d plru=%b exp 0/0/000",
               bus.rsp_set, bus.rsp_way, bus.rsp_plru);
    end
    rst_n = 1'b1;
    wait_sweep("reset_sweep");
  endtask

  task automatic test_back_to_back;
    v_n = 5;
    set_vec(0, 6'd5, 1'b0, 2'd0, 2'd0, 3'b110);
    set_vec(1, 6'd5, 1'b0, 2'd0, 2'd2, 3'b011);
    set_vec(2, 6'd5, 1'b0, 2'd0, 2'd1, 3'b101);
    set_vec(3, 6'd5, 1'b0, 2'd0, 2'd3, 3'b000);
    set_vec(4, 6'd5, 1'b0, 2'd0, 2'd0, 3'b110);
    run_seq("b2b_set5");
  endtask

  task automatic test_hit_then_miss;
    v_n = 2;
    set_vec(0, 6'd9, 1'b1, 2'd2, 2'd2, 3'b001);
    set_vec(1, 6'd9, 1'b0, 2'd3, 2'd0, 3'b111);
    run_seq("hit_miss_set9");
  endtask

  task automatic test_interleave;
    v_n = 4;
    set_vec(0, 6'd1, 1'b0, 2'd0, 2'd0, 3'b110);
    set_vec(1, 6'd2, 1'b0, 2'd0, 2'd0, 3'b110);
    set_vec(2, 6'd1, 1'b0, 2'd0, 2'd2, 3'b011);
    set_vec(3, 6'd2, 1'b0, 2'd0, 2'd2, 3'b011);
    run_seq("interleave");
  endtask

  task automatic test_flush;
    bus.acc_valid = 1'b1;
    bus.acc_set   = 6'd20;
    bus.acc_hit   = 1'b0;
    bus.acc_way   = 2'd0;
    step;
    bus.acc_set = 6'd21;
    flush = 1'b1;
    #1;
    checks++;
    if (bus.acc_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready got=%b exp=0", bus.acc_ready);
    end
    step;
    flush = 1'b0;
    bus.acc_valid = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_set !== 6'd20 ||
        bus.rsp_way !== 2'd0 || bus.rsp_plru !== 3'b110) begin
      errors++;
      $display("FAIL flush_inflight got valid=%b set=%0d way=%0d plru=%b exp valid=1 set=20 way=0 plru=110",
               bus.rsp_valid, bus.rsp_set, bus.rsp_way, bus.rsp_plru);
    end
    wait_sweep("flush_sweep");
    v_n = 2;
    set_vec(0, 6'd5, 1'b0, 2'd0, 2'd0, 3'b110);
    set_vec(1, 6'd9, 1'b0, 2'd0, 2'd0, 3'b110);
    run_seq("after_flush");
  endtask

  task automatic test_reset_mid;
    bus.acc_valid = 1'b1;
    bus.acc_set   = 6'd7;
    bus.acc_hit   = 1'b0;
    bus.acc_way   = 2'd0;
    step;
    bus.acc_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.acc_ready !== 1'b0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got rsp_valid=%b ready=%b done=%b exp 0/0/0",
               bus.rsp_valid, bus.acc_ready, init_done);
    end
    step;
    rst_n = 1'b1;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_drop rsp_valid got=%b exp=0", bus.rsp_valid);
    end
    wait_sweep("reset_mid_sweep");
    v_n = 2;
    set_vec(0, 6'd5, 1'b0, 2'd0, 2'd0, 3'b110);
    set_vec(1, 6'd7, 1'b0, 2'd0, 2'd0, 3'b110);
    run_seq("after_reset");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_back_to_back;
    test_hit_then_miss;
    test_interleave;
    test_flush;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
